// File: rtl/lfsr_delay_timer.sv
// Random-delay source for the reaction timer: free-running Fibonacci LFSR plus a Tick-driven countdown.
// Optional build macro LFSR_DELAY_ABORT_EN adds an Abort input that cancels a running countdown.
module lfsr_delay_timer #(
    parameter int                WIDTH       = 8,
    parameter logic [WIDTH-1:0]  TAPS        = 8'hB8,
    parameter int                DELAY_W     = 12,
    parameter int                MIN_DELAY   = 256,
    parameter int                SCALE_SHIFT = 2
) (
    input  logic               Clock,
    input  logic               Resetn,
    input  logic [WIDTH-1:0]   Seed,
    input  logic               SeedLoad,
    input  logic               Start,
    input  logic               Tick,
`ifdef LFSR_DELAY_ABORT_EN
    input  logic               Abort,
`endif
    output logic [WIDTH-1:0]   Lfsr,
    output logic [DELAY_W-1:0] Delay,
    output logic               Busy,
    output logic               Done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0]   LFSR_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]   LFSR_ZERO = '0;
    localparam logic [DELAY_W-1:0] CNT_ONE   = {{(DELAY_W-1){1'b0}}, 1'b1};
    localparam logic [DELAY_W-1:0] MIN_D     = DELAY_W'(MIN_DELAY);

    // The largest possible draw must fit in DELAY_W, otherwise delays silently wrap.
    if (WIDTH < 3 || WIDTH > 16) begin : g_bad_width
        $error("lfsr_delay_timer: WIDTH must be in 3..16");
    end
    if ((longint'(MIN_DELAY) + ((longint'(1) << WIDTH) - 1) * (longint'(1) << SCALE_SHIFT))
            >= (longint'(1) << DELAY_W)) begin : g_bad_range
        $error("lfsr_delay_timer: MIN_DELAY + max scaled draw does not fit in DELAY_W");
    end

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_lfsr;
    logic [WIDTH-1:0]   w_lfsr_next;
    logic               w_feedback;
    logic [DELAY_W-1:0] r_delay;
    logic [DELAY_W-1:0] w_delay_next;
    logic [DELAY_W-1:0] r_count;
    logic [DELAY_W-1:0] w_count_next;
    logic [DELAY_W-1:0] w_draw;
    logic               w_abort;

`ifdef LFSR_DELAY_ABORT_EN
    assign w_abort = Abort;
`else
    assign w_abort = 1'b0;
`endif

    // LFSR runs every Clock so the moment the player presses Start picks the value.
    always_comb begin
        w_feedback = ^(r_lfsr & TAPS);
        if (SeedLoad) begin
            w_lfsr_next = (Seed == LFSR_ZERO) ? LFSR_ONE : Seed;
        end else if (r_lfsr == LFSR_ZERO) begin
            w_lfsr_next = LFSR_ONE;
        end else begin
            w_lfsr_next = {r_lfsr[WIDTH-2:0], w_feedback};
        end
    end

    // Draw uses the pre-edge LFSR, so a coincident SeedLoad does not affect it.
    assign w_draw = MIN_D + (DELAY_W'(r_lfsr) << SCALE_SHIFT);

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        w_state_next = r_state;
        w_delay_next = r_delay;
        w_count_next = r_count;
        case (r_state)
            S_IDLE: begin
                if (Start) begin
                    w_delay_next = w_draw;
                    w_count_next = w_draw;
                    w_state_next = S_COUNT;
                end
            end
            S_COUNT: begin
                if (w_abort) begin
                    w_count_next = '0;
                    w_state_next = S_IDLE;
                end else if (Tick) begin
                    w_count_next = r_count - CNT_ONE;
                    if (r_count == CNT_ONE) begin
                        w_state_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= S_IDLE;
            r_lfsr  <= LFSR_ONE;
            r_delay <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_lfsr  <= w_lfsr_next;
            r_delay <= w_delay_next;
            r_count <= w_count_next;
        end
    end

    assign Lfsr  = r_lfsr;
    assign Delay = r_delay;
    assign Busy  = (r_state == S_COUNT);
    assign Done  = (r_state == S_DONE);

endmodule

// File: tb/tb_lfsr_delay_timer.sv
// Directed bench for lfsr_delay_timer at WIDTH=4, TAPS=4'hC, MIN_DELAY=16, SCALE_SHIFT=2.
// Build with LFSR_DELAY_ABORT_EN defined to also cover the Abort path.
module tb_lfsr_delay_timer;

    localparam int WIDTH   = 4;
    localparam int DELAY_W = 8;

    logic               Clock;
    logic               Resetn;
    logic [WIDTH-1:0]   Seed;
    logic               SeedLoad;
    logic               Start;
    logic               Tick;
`ifdef LFSR_DELAY_ABORT_EN
    logic               Abort;
`endif
    logic [WIDTH-1:0]   Lfsr;
    logic [DELAY_W-1:0] Delay;
    logic               Busy;
    logic               Done;

    int n_assert = 0;
    int n_fail   = 0;

    lfsr_delay_timer #(
        .WIDTH      (WIDTH),
        .TAPS       (4'hC),
        .DELAY_W    (DELAY_W),
        .MIN_DELAY  (16),
        .SCALE_SHIFT(2)
    ) dut (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .Seed    (Seed),
        .SeedLoad(SeedLoad),
        .Start   (Start),
        .Tick    (Tick),
`ifdef LFSR_DELAY_ABORT_EN
        .Abort   (Abort),
`endif
        .Lfsr    (Lfsr),
        .Delay   (Delay),
        .Busy    (Busy),
        .Done    (Done)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Each counted Tick is followed by one idle cycle, so the countdown ignores non-Tick cycles.
    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            Tick = 1'b1;
            step();
            Tick = 1'b0;
            step();
        end
    endtask

    // Seed the LFSR to 9, then Start with a coincident Tick that must not be counted.
    task automatic load_and_start(input string tag);
        Seed = 4'h9; SeedLoad = 1'b1;
        step();
        SeedLoad = 1'b0;
        chk({tag, "_lfsr9"}, 32'(Lfsr), 32'h9);
        Start = 1'b1; Tick = 1'b1;
        step();
        Start = 1'b0; Tick = 1'b0;
        chk({tag, "_delay"}, 32'(Delay), 32'd52);
        chk({tag, "_busy"},  32'(Busy),  32'd1);
    endtask

    logic [3:0] exp_seq [16] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                                 4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};
    logic saw_activity;

    initial begin
        Resetn = 1'b0; Seed = '0; SeedLoad = 1'b0; Start = 1'b0; Tick = 1'b0;
`ifdef LFSR_DELAY_ABORT_EN
        Abort = 1'b0;
`endif
        step();
        step();
        chk("rst_lfsr",  32'(Lfsr),  32'h1);
        chk("rst_delay", 32'(Delay), 32'h0);
        chk("rst_busy",  32'(Busy),  32'h0);
        chk("rst_done",  32'(Done),  32'h0);

        // Full period of the 4-bit sequence.
        Resetn = 1'b1;
        chk("seq_0", 32'(Lfsr), 32'(exp_seq[0]));
        for (int i = 1; i < 16; i++) begin
            step();
            chk($sformatf("seq_%0d", i), 32'(Lfsr), 32'(exp_seq[i]));
        end

        // Seed guard.
        Seed = 4'h0; SeedLoad = 1'b1;
        step();
        SeedLoad = 1'b0;
        chk("seed_zero", 32'(Lfsr), 32'h1);
        Seed = 4'hA; SeedLoad = 1'b1;
        step();
        SeedLoad = 1'b0;
        chk("seed_a", 32'(Lfsr), 32'hA);
        step();
        chk("seed_a_next", 32'(Lfsr), 32'h5);

        // Ticks in IDLE do nothing.
        Tick = 1'b1;
        step();
        step();
        Tick = 1'b0;
        chk("idle_tick_busy", 32'(Busy), 32'h0);
        chk("idle_tick_done", 32'(Done), 32'h0);

        // Countdown: 51 Ticks give no Done, the 52nd does.
        load_and_start("cd");
        ticks(51);
        chk("cd51_done", 32'(Done), 32'h0);
        chk("cd51_busy", 32'(Busy), 32'h1);
        Tick = 1'b1;
        step();
        Tick = 1'b0;
        chk("cd52_done", 32'(Done), 32'h1);
        chk("cd52_busy", 32'(Busy), 32'h0);
        // Start during DONE is ignored.
        Start = 1'b1;
        step();
        Start = 1'b0;
        chk("cd_pulse_end", 32'(Done),  32'h0);
        chk("cd_start_in_done_busy", 32'(Busy), 32'h0);
        chk("cd_delay_hold", 32'(Delay), 32'd52);

        // Start while Busy is ignored.
        load_and_start("ign");
        ticks(10);
        Seed = 4'hF; SeedLoad = 1'b1; Start = 1'b1;
        step();
        SeedLoad = 1'b0; Start = 1'b0;
        chk("ign_delay", 32'(Delay), 32'd52);
        chk("ign_busy",  32'(Busy),  32'h1);
        ticks(41);
        chk("ign51_done", 32'(Done), 32'h0);
        Tick = 1'b1;
        step();
        Tick = 1'b0;
        chk("ign52_done", 32'(Done), 32'h1);
        step();

        // SeedLoad with Start: draw from pre-load value, seed applied on the same edge.
        Seed = 4'h9; SeedLoad = 1'b1;
        step();
        Seed = 4'h3; Start = 1'b1;
        step();
        SeedLoad = 1'b0; Start = 1'b0;
        chk("sls_delay", 32'(Delay), 32'd52);
        chk("sls_lfsr",  32'(Lfsr),  32'h3);

        // Reset mid-count aborts immediately with no Done afterwards.
        ticks(20);
        Resetn = 1'b0;
        #1;
        chk("rmc_busy",  32'(Busy),  32'h0);
        chk("rmc_delay", 32'(Delay), 32'h0);
        chk("rmc_lfsr",  32'(Lfsr),  32'h1);
        chk("rmc_done",  32'(Done),  32'h0);
        step();
        Resetn = 1'b1;
        saw_activity = 1'b0;
        for (int i = 0; i < 40; i++) begin
            Tick = 1'b1;
            step();
            Tick = 1'b0;
            if (Done !== 1'b0 || Busy !== 1'b0) saw_activity = 1'b1;
        end
        chk("rmc_no_done", 32'(saw_activity), 32'h0);

`ifdef LFSR_DELAY_ABORT_EN
        // Abort beats a coincident expiring Tick.
        load_and_start("ab");
        ticks(51);
        Tick = 1'b1; Abort = 1'b1;
        step();
        Tick = 1'b0; Abort = 1'b0;
        chk("ab_busy",  32'(Busy),  32'h0);
        chk("ab_done",  32'(Done),  32'h0);
        chk("ab_delay", 32'(Delay), 32'd52);
        step();
        chk("ab_done_late", 32'(Done), 32'h0);
        Seed = 4'hA; SeedLoad = 1'b1;
        step();
        SeedLoad = 1'b0; Start = 1'b1;
        step();
        Start = 1'b0;
        chk("ab_restart_delay", 32'(Delay), 32'd56);
        chk("ab_restart_busy",  32'(Busy),  32'h1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/lfsr_delay_timer.md
Name: lfsr_delay_timer

Overview:
- Parametrised successor to the team's 4-bit LFSR random-delay source for the reaction timer.
- Free-running Fibonacci LFSR of configurable width and taps, with zero-lock protection and seed load.
- On Start, draws one random value and scales it into a bounded delay.
- Counts the delay down on an external Tick strobe from the divided clock, then pulses Done to the reaction-timer control FSM, which lights the stimulus LED.

Parameters:
- WIDTH, 8, LFSR width in bits (legal range 3..16).
- TAPS, 8'hB8, feedback mask of WIDTH bits; bit i set means state[i] enters the XOR.
- DELAY_W, 12, width of Delay and of the internal counter.
- MIN_DELAY, 256, minimum delay in Ticks.
- SCALE_SHIFT, 2, left shift applied to the random draw.

Ports:
- Clock  in  1  system clock; all state changes on its rising edge.
- Resetn  in  1  asynchronous active-low reset.
- Seed  in  WIDTH  seed value, used on SeedLoad.
- SeedLoad  in  1  single-cycle request to load Seed into the LFSR.
- Start  in  1  single-cycle request for a new random delay.
- Tick  in  1  single-cycle count-enable strobe (divided time base).
- Lfsr  out  WIDTH  current LFSR state, for observability.
- Delay  out  DELAY_W  delay captured at the most recent accepted Start.
- Busy  out  1  high while counting down.
- Done  out  1  one-Clock pulse when the countdown expires.

Behaviour:
- Reset (async, Resetn=0):
  - Lfsr=1; Delay=0; counter=0; Busy=0; Done=0; FSM=IDLE.
  - Reset mid-count aborts immediately, with no Done.
- LFSR:
  - Advances on every Clock, not gated by Tick, so player timing supplies entropy.
  - next = {state[WIDTH-2:0], ^(state & TAPS)}.
  - SeedLoad: next = Seed, or 1 if Seed==0.
  - If state==0 is ever reached, next = 1. The state is never 0 for more than one cycle.
- Draw (computed from Lfsr before the edge):
  - Draw = MIN_DELAY + (Lfsr << SCALE_SHIFT), truncated to DELAY_W.
  - Elaboration check: MIN_DELAY + ((2^WIDTH-1) << SCALE_SHIFT) < 2^DELAY_W; otherwise $error.
  - Lfsr is never 0, so Draw >= 1 always.
- FSM states:
  - IDLE: Busy=0. Start → Delay<=Draw, counter<=Draw, go COUNT.
  - COUNT: Busy=1. Each Tick decrements counter. Tick with counter==1 → go DONE.
  - DONE: Done=1 for exactly one Clock, Busy=0, unconditionally return to IDLE.
- Timing:
  - Busy rises the Clock after Start is accepted.
  - Ticks count from the cycle after capture. A Tick coincident with the accepted Start is not counted.
  - Done asserts the Clock after the Delay-th counted Tick.
- Simultaneous and boundary events:
  - Start while in COUNT or DONE is ignored; Delay and counter are unchanged.
  - SeedLoad together with Start: Draw uses the pre-load Lfsr; the seed takes effect on the same edge.
  - Tick outside COUNT has no effect.
  - Delay holds its value until the next accepted Start.
- Widths: all arithmetic is unsigned. The counter never underflows, because it leaves COUNT at 1.

Optional Feature:
- Macro: LFSR_DELAY_ABORT_EN.
- When defined:
  - Adds input port Abort (1 bit).
  - Abort in COUNT → IDLE on the next Clock: Busy=0, no Done, counter cleared, Delay retained.
  - Abort takes priority over a coincident expiring Tick.
  - Abort in IDLE or DONE is ignored.
- When undefined: the Abort port is absent, and the countdown always completes to Done unless Resetn asserts.

Test Plan:
- Sequence (WIDTH=4, TAPS=4'hC): release reset → Lfsr = 1,2,4,9,3,6,D,A,5,B,7,F,E,C,8,1 on consecutive Clocks (period 15, never 0).
- Seed guard: SeedLoad with Seed=0 → Lfsr=1 next cycle. SeedLoad with Seed=4'hA → Lfsr=A next cycle, then 5.
- Countdown (WIDTH=4, TAPS=4'hC, MIN_DELAY=16, SCALE_SHIFT=2): Start when Lfsr=9 → Delay=52, Busy high next Clock. After 52 Ticks, Done is a one-Clock pulse and Busy=0. 51 Ticks gives no Done.
- Start ignored: second Start while Busy (after 10 Ticks) → Delay stays 52, and Done still arrives after 42 further Ticks.
- Reset mid-count: assert Resetn=0 at tick 20 of 52 → Busy=0, Delay=0, Lfsr=1 immediately; no Done after release.
- Abort (LFSR_DELAY_ABORT_EN): Abort together with the 52nd Tick → IDLE, no Done, Delay=52 retained. A subsequent Start is accepted.
